uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Receive-side frame buffer sitting directly downstream of `uart_rx`. It captures each completed frame on the rising edge of the receiver's `ready` strobe, together with its parity-error flag, into a DEPTH-entry circular buffer. It presents the oldest entry on a first-word-fall-through valid/ready port for the consuming logic. A sticky overflow flag records frames lost to a full buffer.

## Interface

Parameters:

- `DATA_LENGTH`, default `` `DATA_LENGTH ``: frame payload width; must match `uart_rx`.
- `DEPTH`, default 16: number of entries; power of two, ≥ 2.

Ports:

- `sysclk` input 1: system clock; all state updates on its rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `rx_ready` input 1: `uart_rx` `ready`; a frame is complete on its rising edge.
- `rx_error` input 1: `uart_rx` `error`; sampled with `rx_ready`.
- `rx_data` input DATA_LENGTH: `uart_rx` `data`; sampled with `rx_ready`.
- `out_valid` output 1: buffer non-empty; `out_data`/`out_error` valid.
- `out_ready` input 1: consumer accepts the head entry when high together with `out_valid`.
- `out_data` output DATA_LENGTH: payload of the head entry.
- `out_error` output 1: parity-error flag of the head entry.
- `count` output $clog2(DEPTH+1): current number of stored entries.
- `overflow` output 1: sticky; set when a frame is dropped because the buffer is full.
- `clear_overflow` input 1: synchronous clear of `overflow`.

## Operation

- Edge detect: register `rx_ready_q`. Write request `wr = rx_ready & ~rx_ready_q`. A level held high produces exactly one write.
- Pop: `rd = out_valid & out_ready`.
- Storage: memory of DEPTH × (DATA_LENGTH+1) bits holds `{error, data}`. Write pointer and read pointer are each $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Write accepted when `count < DEPTH`, or when `count == DEPTH` and `rd` is high in the same cycle (slot freed).
- Write rejected when `count == DEPTH` and `rd` is low. The frame is discarded, pointers and count are unchanged, and `overflow` is set.
- Count update:
  - accepted write only: +1
  - pop only: −1
  - both: unchanged
  - neither: unchanged
- `out_valid = (count != 0)`. `out_data` and `out_error` are read combinationally from `mem[rd_ptr]`.
- `out_ready` while `out_valid` is low has no effect.
- Overflow: `clear_overflow` clears it. If a set and `clear_overflow` occur in the same cycle, set wins.
- Reset (asynchronous, any time, including mid-write):
  - `rd_ptr`, `wr_ptr`, `count` = 0
  - `overflow` = 0
  - `rx_ready_q` = 1, so an `rx_ready` held high across reset release does not cause a spurious write
  - memory contents are not reset
- Resulting output values during and after reset: `out_valid` = 0, `count` = 0, `overflow` = 0. `out_data`/`out_error` are don't-care while `out_valid` is 0.

## Timing

- Write latency: when `rx_ready` is sampled high at edge E with `rx_ready_q` = 0, the entry is written at edge E. `count` and `out_valid` update immediately after E.
- Pop latency: a pop at edge E advances `rd_ptr`. The next entry (or `out_valid` = 0) is visible after E.
- Throughput: one write and one pop per cycle.
- `uart_rx` emits at most one `ready` pulse per frame, well below the one-write-per-cycle limit.

## Configuration

- Macro: `UART_RX_FIFO_DROP_ERR_EN`.
- When defined:
  - Frames with `rx_error` = 1 are never written and do not affect `overflow`.
  - An additional 8-bit output `err_drop_cnt` counts them, saturating at 255, reset to 0.
  - `out_error` is tied to 0.
- When undefined: errored frames are stored like any other with `out_error` = 1, and the `err_drop_cnt` port does not exist.

## Test plan

Benches use DEPTH = 4 and DATA_LENGTH = 8.

1. Basic write/read: single `rx_ready` pulse with `rx_data` = 0x41, `rx_error` = 0.
   - Next cycle: `out_valid` = 1, `out_data` = 0x41, `count` = 1.
   - One-cycle `out_ready` → `out_valid` = 0, `count` = 0.
2. Order and wrap: write 0x01..0x06 while popping after every two writes.
   - Read sequence is exactly 0x01..0x06, with no loss across the pointer wrap.
3. Full and overflow: five pulses 0x10..0x14 with no reads.
   - `count` = 4, `overflow` = 1.
   - Reads return 0x10..0x13.
   - `clear_overflow` → `overflow` = 0.
4. Simultaneous events:
   - With `count` = 4, a pulse 0x55 in the same cycle as a pop is accepted: `count` stays 4, `overflow` stays 0, and 0x55 is read last.
   - An overflow event in the same cycle as `clear_overflow` leaves `overflow` = 1.
5. Edge/reset robustness:
   - `rx_ready` held high for 5 cycles → exactly one entry.
   - Assert `reset` with `count` = 3 while `rx_ready` stays high, then release → `count` = 0, `out_valid` = 0, and no new entry until `rx_ready` falls and rises again.
6. Error handling: a pulse with `rx_error` = 1 and `rx_data` = 0x7E.
   - Macro undefined: entry stored with `out_error` = 1.
   - Macro defined: `count` stays 0 and `err_drop_cnt` = 1.

Source files
------------

// File: rtl/uart_rx_fifo_if.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo_if
// Bundles the receiver-side capture signals and the consumer-side
// first-word-fall-through port of uart_rx_fifo.
//
// Optional feature macro: UART_RX_FIFO_DROP_ERR_EN (adds err_drop_cnt).
//
// Signals:
//   rx_ready / rx_error / rx_data : frame strobe, parity flag and payload from uart_rx
//   out_valid / out_ready         : head-entry handshake
//   out_data / out_error          : head-entry payload and parity flag
//   count                         : number of stored entries
//   overflow / clear_overflow     : sticky drop flag and its synchronous clear
//   err_drop_cnt                  : (macro only) saturating count of dropped errored frames
//
// Modports:
//   slave  - the FIFO side
//   master - the environment driving the receiver and consumer side
// -----------------------------------------------------------------------------
`ifndef DATA_LENGTH
`define DATA_LENGTH 8
`endif

interface uart_rx_fifo_if #(
  parameter int DATA_LENGTH = `DATA_LENGTH,
  parameter int DEPTH       = 16
);
  localparam int CW = $clog2(DEPTH + 1);

  logic                   rx_ready;
  logic                   rx_error;
  logic [DATA_LENGTH-1:0] rx_data;
  logic                   out_valid;
  logic                   out_ready;
  logic [DATA_LENGTH-1:0] out_data;
  logic                   out_error;
  logic [CW-1:0]          count;
  logic                   overflow;
  logic                   clear_overflow;
`ifdef UART_RX_FIFO_DROP_ERR_EN
  logic [7:0]             err_drop_cnt;
`endif

  modport slave (
    input  rx_ready, rx_error, rx_data, out_ready, clear_overflow,
    output out_valid, out_data, out_error, count, overflow
`ifdef UART_RX_FIFO_DROP_ERR_EN
    , output err_drop_cnt
`endif
  );

  modport master (
    output rx_ready, rx_error, rx_data, out_ready, clear_overflow,
    input  out_valid, out_data, out_error, count, overflow
`ifdef UART_RX_FIFO_DROP_ERR_EN
    , input err_drop_cnt
`endif
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo
// Frame buffer behind uart_rx. Every rising edge of rx_ready captures
// {rx_error, rx_data} into a DEPTH-entry circular buffer; the oldest entry is
// presented on a first-word-fall-through valid/ready port. A frame arriving
// while the buffer is full (and no pop frees a slot in the same cycle) is
// discarded and sets the sticky overflow flag.
//
// Optional feature macro: UART_RX_FIFO_DROP_ERR_EN
//   defined   : errored frames are discarded and counted in err_drop_cnt
//               (saturating at 255); out_error is tied low.
//   undefined : errored frames are stored with their error flag.
//
// Ports:
//   sysclk : system clock, rising edge
//   reset  : asynchronous active-high reset
//   bus    : uart_rx_fifo_if.slave (see interface header for signal list)
// -----------------------------------------------------------------------------
`ifndef DATA_LENGTH
`define DATA_LENGTH 8
`endif

module uart_rx_fifo #(
  parameter int DATA_LENGTH = `DATA_LENGTH,
  parameter int DEPTH       = 16
) (
  input  logic           sysclk,
  input  logic           reset,
  uart_rx_fifo_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int EW = DATA_LENGTH + 1;

  // Storage: {error, data}; intentionally not reset
  logic [EW-1:0] r_mem [DEPTH];

  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_overflow;
  logic          r_rx_ready_q;

  logic          w_wr_req;
  logic          w_wr_frame;
  logic          w_full;
  logic          w_valid;
  logic          w_rd;
  logic          w_wr_acc;
  logic          w_wr_rej;
  logic [EW-1:0] w_head;

  // A level held high yields a single request
  assign w_wr_req = bus.rx_ready & ~r_rx_ready_q;

`ifdef UART_RX_FIFO_DROP_ERR_EN
  logic       w_err_drop;
  logic [7:0] r_err_drop_cnt;

  assign w_err_drop = w_wr_req & bus.rx_error;
  assign w_wr_frame = w_wr_req & ~bus.rx_error;
`else
  assign w_wr_frame = w_wr_req;
`endif

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_valid = (r_count != {CW{1'b0}});
  assign w_rd    = w_valid & bus.out_ready;

  // A pop in the same cycle frees the slot a full buffer needs
  assign w_wr_acc = w_wr_frame & (~w_full | w_rd);
  assign w_wr_rej = w_wr_frame & w_full & ~w_rd;

  assign w_head = r_mem[r_rd_ptr];

  // Memory write port
  always_ff @(posedge sysclk) begin
    if (w_wr_acc) begin
      r_mem[r_wr_ptr] <= {bus.rx_error, bus.rx_data};
    end
  end

  // Edge detector, pointers, occupancy and sticky overflow
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      r_rx_ready_q <= 1'b1;  // a high rx_ready across reset release is not a new frame
      r_wr_ptr     <= {AW{1'b0}};
      r_rd_ptr     <= {AW{1'b0}};
      r_count      <= {CW{1'b0}};
      r_overflow   <= 1'b0;
    end else begin
      r_rx_ready_q <= bus.rx_ready;

      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end

      if (w_rd) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end

      case ({w_wr_acc, w_rd})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase

      // Set has priority over clear
      if (w_wr_rej) begin
        r_overflow <= 1'b1;
      end else if (bus.clear_overflow) begin
        r_overflow <= 1'b0;
      end
    end
  end

`ifdef UART_RX_FIFO_DROP_ERR_EN
  // Saturating count of discarded errored frames
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      r_err_drop_cnt <= 8'd0;
    end else if (w_err_drop && (r_err_drop_cnt != 8'd255)) begin
      r_err_drop_cnt <= r_err_drop_cnt + 8'd1;
    end
  end

  assign bus.err_drop_cnt = r_err_drop_cnt;
  assign bus.out_error    = 1'b0;
`else
  assign bus.out_error    = w_head[DATA_LENGTH];
`endif

  assign bus.out_valid = w_valid;
  assign bus.out_data  = w_head[DATA_LENGTH-1:0];
  assign bus.count     = r_count;
  assign bus.overflow  = r_overflow;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_fifo
// Directed scenarios followed by random traffic, checked every cycle against
// a queue-based reference model of the buffer (DEPTH = 4, DATA_LENGTH = 8).
// -----------------------------------------------------------------------------
module tb_uart_rx_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 4;

  logic sysclk = 1'b0;
  logic reset  = 1'b1;

  uart_rx_fifo_if #(.DATA_LENGTH(DW), .DEPTH(DEPTH)) bus ();

  uart_rx_fifo #(.DATA_LENGTH(DW), .DEPTH(DEPTH)) dut (
    .sysclk (sysclk),
    .reset  (reset),
    .bus    (bus)
  );

  always #5 sysclk = ~sysclk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Reference model: FIFO contents as a queue of {error, data}
  logic [DW:0] mq [$];
  logic        m_ovf  = 1'b0;
  logic        m_prev = 1'b1;
  int          m_drop = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    chk("count", 32'(bus.count), 32'(mq.size()));
    chk("out_valid", 32'(bus.out_valid), 32'(mq.size() != 0));
    chk("overflow", 32'(bus.overflow), 32'(m_ovf));
`ifdef UART_RX_FIFO_DROP_ERR_EN
    chk("err_drop_cnt", 32'(bus.err_drop_cnt), 32'(m_drop));
`endif
    if (mq.size() != 0) begin
      chk("out_data", 32'(bus.out_data), 32'(mq[0][DW-1:0]));
      chk("out_error", 32'(bus.out_error), 32'(mq[0][DW]));
    end
  endtask

  // One clock cycle with the given inputs, then model update and comparison
  task automatic step(input logic rdy, input logic err, input logic [DW-1:0] d,
                      input logic ordy, input logic clr);
    bit pop, wr;
    bus.rx_ready       = rdy;
    bus.rx_error       = err;
    bus.rx_data        = d;
    bus.out_ready      = ordy;
    bus.clear_overflow = clr;
    pop = (mq.size() != 0) && ordy;
    wr  = rdy && !m_prev;
    @(posedge sysclk);
    #1;
    m_prev = rdy;
`ifdef UART_RX_FIFO_DROP_ERR_EN
    if (wr && err) begin
      if (m_drop < 255) m_drop++;
      wr = 1'b0;
    end
`endif
    if (pop) void'(mq.pop_front());
    if (wr && mq.size() >= DEPTH) begin
      m_ovf = 1'b1;
    end else begin
      if (wr) mq.push_back({err, d});
      if (clr) m_ovf = 1'b0;
    end
    compare_all();
  endtask

  task automatic pulse(input logic [DW-1:0] d, input logic err);
    step(1'b1, err, d, 1'b0, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic pop1();
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
  endtask

  // Reset asserted mid-cycle with rx_ready left as it is
  task automatic do_reset();
    reset = 1'b1;
    #1;
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_count", 32'(bus.count), 32'd0);
    chk("rst_overflow", 32'(bus.overflow), 32'd0);
    repeat (2) @(posedge sysclk);
    #1;
    reset = 1'b0;
    mq.delete();
    m_ovf  = 1'b0;
    m_prev = 1'b1;
    m_drop = 0;
  endtask

  initial begin
    bus.rx_ready       = 1'b0;
    bus.rx_error       = 1'b0;
    bus.rx_data        = 8'h00;
    bus.out_ready      = 1'b0;
    bus.clear_overflow = 1'b0;

    do_reset();
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);

    // 1. basic write/read
    pulse(8'h41, 1'b0);
    chk("t1_data", 32'(bus.out_data), 32'h41);
    chk("t1_count", 32'(bus.count), 32'd1);
    pop1();
    chk("t1_valid", 32'(bus.out_valid), 32'd0);

    // 2. order across pointer wrap
    for (int i = 1; i <= 6; i++) begin
      pulse(8'(i), 1'b0);
      if (i % 2 == 0) begin
        chk("t2_order", 32'(bus.out_data), 32'(i - 1));
        pop1();
        chk("t2_order", 32'(bus.out_data), 32'(i));
        pop1();
      end
    end
    chk("t2_empty", 32'(bus.count), 32'd0);

    // 3. full and overflow
    for (int i = 0; i < 5; i++) pulse(8'(8'h10 + i), 1'b0);
    chk("t3_count", 32'(bus.count), 32'd4);
    chk("t3_ovf", 32'(bus.overflow), 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk("t3_read", 32'(bus.out_data), 32'(8'h10 + i));
      pop1();
    end
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    chk("t3_clear", 32'(bus.overflow), 32'd0);

    // 4. write with pop while full; overflow with clear in same cycle
    for (int i = 0; i < 4; i++) pulse(8'(8'h20 + i), 1'b0);
    step(1'b1, 1'b0, 8'h55, 1'b1, 1'b0);
    chk("t4_count", 32'(bus.count), 32'd4);
    chk("t4_ovf", 32'(bus.overflow), 32'd0);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    repeat (3) pop1();
    chk("t4_last", 32'(bus.out_data), 32'h55);
    pop1();
    for (int i = 0; i < 4; i++) pulse(8'(8'h30 + i), 1'b0);
    step(1'b1, 1'b0, 8'h99, 1'b0, 1'b1);
    chk("t4_set_wins", 32'(bus.overflow), 32'd1);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    repeat (4) pop1();

    // 5. held level and reset with rx_ready high
    repeat (5) step(1'b1, 1'b0, 8'h33, 1'b0, 1'b0);
    chk("t5_held", 32'(bus.count), 32'd1);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    pulse(8'h34, 1'b0);
    step(1'b1, 1'b0, 8'h35, 1'b0, 1'b0);
    chk("t5_pre", 32'(bus.count), 32'd3);
    do_reset();
    repeat (2) step(1'b1, 1'b0, 8'h36, 1'b0, 1'b0);
    chk("t5_nospur", 32'(bus.count), 32'd0);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'h5A, 1'b0, 1'b0);
    chk("t5_rearm", 32'(bus.count), 32'd1);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);

    // 6. errored frame
    pulse(8'h7E, 1'b1);
`ifdef UART_RX_FIFO_DROP_ERR_EN
    chk("t6_count", 32'(bus.count), 32'd0);
    chk("t6_drop", 32'(bus.err_drop_cnt), 32'd1);
`else
    chk("t6_count", 32'(bus.count), 32'd1);
    chk("t6_err", 32'(bus.out_error), 32'd1);
    chk("t6_data", 32'(bus.out_data), 32'h7E);
    pop1();
`endif

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
           8'($urandom_range(0, 255)), 1'($urandom_range(0, 2) == 0),
           1'($urandom_range(0, 7) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
